keypad_psswrd_entry: RTL and testbench

KEYPAD_PSSWRD_ENTRY -- requirements
Module: keypad_psswrd_entry

---
 rtl/keypad_psswrd_entry_pkg.sv | 20 ++
 rtl/keypad_timeout_cnt.sv | 27 ++
 rtl/keypad_psswrd_entry.sv | 120 ++++++++++++
 tb/tb_keypad_psswrd_entry.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_psswrd_entry_pkg.sv
// Shared state encoding and key codes for the keypad password entry block.
// Used by keypad_psswrd_entry and its optional timeout counter.
package keypad_psswrd_entry_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        D1   = 3'd1,
        D2   = 3'd2,
        SEND = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/keypad_timeout_cnt.sv
// Inactivity counter: clears on any key, counts while digits are held.
// expired is asserted combinationally when the count hits TIMEOUT_CYCLES-1.
module keypad_timeout_cnt #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [15:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= 16'd0;
        end else if (clr) begin
            cnt_reg <= 16'd0;
        end else if (en) begin
            cnt_reg <= cnt_reg + 16'd1;
        end
    end

    assign expired = en && (cnt_reg == (TIMEOUT_CYCLES - 16'd1));

endmodule

// File: rtl/keypad_psswrd_entry.sv
// Two-digit keypad password entry FSM producing an 8-bit attempt and a try pulse.
// Optional inactivity timeout enabled by defining KEYPAD_TIMEOUT_EN.
module keypad_psswrd_entry
    import keypad_psswrd_entry_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] psswrd_atmpt,
    output logic       try_psswrd,
    output logic [1:0] digit_count,
    output logic       entry_error
);

    state_t     state_reg, state_next;
    logic [7:0] value_reg, value_next;
    logic [7:0] atmpt_reg, atmpt_next;
    logic       timeout_expired;
    logic       held_state;

    assign held_state = (state_reg == D1) || (state_reg == D2) || (state_reg == ERR);

`ifdef KEYPAD_TIMEOUT_EN
    keypad_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (key_valid),
        .en     (held_state),
        .expired(timeout_expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES ^ held_state;
    assign timeout_expired    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            value_reg <= 8'd0;
            atmpt_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            value_reg <= value_next;
            atmpt_reg <= atmpt_next;
        end
    end

    // value_reg accumulates the held digits as a binary number (max 99).
    always_comb begin
        state_next = state_reg;
        value_next = value_reg;
        atmpt_next = atmpt_reg;
        case (state_reg)
            IDLE: begin
                if (key_valid && is_digit(key_code)) begin
                    value_next = {4'd0, key_code};
                    state_next = D1;
                end
            end
            D1, D2: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        if (state_reg == D1) begin
                            value_next = value_reg * 8'd10 + {4'd0, key_code};
                            state_next = D2;
                        end else begin
                            value_next = 8'd0;
                            state_next = ERR;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        atmpt_next = value_reg;
                        value_next = 8'd0;
                        state_next = SEND;
                    end else if (key_code == KEY_CLEAR) begin
                        value_next = 8'd0;
                        state_next = IDLE;
                    end
                end
            end
            SEND: begin
                value_next = 8'd0;
                state_next = IDLE;
            end
            ERR: begin
                if (key_valid && (key_code == KEY_CLEAR)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                value_next = 8'd0;
                state_next = IDLE;
            end
        endcase
        // A keystroke counts as activity, so it wins over a simultaneous timeout.
        if (timeout_expired && !key_valid) begin
            value_next = 8'd0;
            state_next = IDLE;
        end
    end

    always_comb begin
        digit_count = 2'd0;
        case (state_reg)
            D1:      digit_count = 2'd1;
            D2:      digit_count = 2'd2;
            default: digit_count = 2'd0;
        endcase
    end

    assign try_psswrd   = (state_reg == SEND);
    assign entry_error  = (state_reg == ERR);
    assign psswrd_atmpt = atmpt_reg;

endmodule

// File: tb/tb_keypad_psswrd_entry.sv
// Self-checking bench: directed scenarios then random keys against a digit-list model.
// Timeout scenarios run when KEYPAD_TIMEOUT_EN is defined (TIMEOUT_CYCLES=10).
module tb_keypad_psswrd_entry;

    localparam int T_CYC = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [7:0] psswrd_atmpt;
    logic       try_psswrd;
    logic [1:0] digit_count;
    logic       entry_error;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned m_digits[$];
    bit          m_err;
    bit          m_send;
    logic [7:0]  m_atmpt;
    int          m_idle;

    keypad_psswrd_entry #(
        .TIMEOUT_CYCLES(16'd10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .psswrd_atmpt(psswrd_atmpt),
        .try_psswrd  (try_psswrd),
        .digit_count (digit_count),
        .entry_error (entry_error)
    );

    always #5 clk = ~clk;

    // Model of one clock edge, expressed as operations on the list of held digits.
    task automatic model_step(input logic v, input logic [3:0] c, input logic r);
        bit held;
        held = (m_digits.size() > 0) || m_err;
        if (r) begin
            m_digits.delete();
            m_err = 0; m_send = 0; m_atmpt = 8'd0; m_idle = 0;
        end else if (m_send) begin
            m_send = 0;
            m_digits.delete();
            if (v) m_idle = 0;
        end else if (v) begin
            m_idle = 0;
            if (c == 4'hA) begin
                m_digits.delete();
                m_err = 0;
            end else if (c == 4'hB) begin
                if (!m_err && m_digits.size() > 0) begin
                    if (m_digits.size() == 1) m_atmpt = 8'(m_digits[0]);
                    else m_atmpt = 8'(m_digits[0] * 10 + m_digits[1]);
                    m_send = 1;
                    m_digits.delete();
                end
            end else if (c <= 4'd9) begin
                if (!m_err) begin
                    if (m_digits.size() == 2) begin
                        m_err = 1;
                        m_digits.delete();
                    end else begin
                        m_digits.push_back(int'(c));
                    end
                end
            end
        end else begin
`ifdef KEYPAD_TIMEOUT_EN
            if (held) begin
                if (m_idle == T_CYC - 1) begin
                    m_digits.delete();
                    m_err = 0;
                end else begin
                    m_idle++;
                end
            end
`else
            held = held;
`endif
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [1:0] exp_cnt;
        exp_cnt = (m_send || m_err) ? 2'd0 : 2'(m_digits.size());
        n_checks++;
        assert (try_psswrd === m_send) else begin
            n_fail++;
            $error("FAIL %s try_psswrd observed=%0b expected=%0b", tag, try_psswrd, m_send);
        end
        n_checks++;
        assert (psswrd_atmpt === m_atmpt) else begin
            n_fail++;
            $error("FAIL %s psswrd_atmpt observed=%02h expected=%02h", tag, psswrd_atmpt, m_atmpt);
        end
        n_checks++;
        assert (digit_count === exp_cnt) else begin
            n_fail++;
            $error("FAIL %s digit_count observed=%0d expected=%0d", tag, digit_count, exp_cnt);
        end
        n_checks++;
        assert (entry_error === m_err) else begin
            n_fail++;
            $error("FAIL %s entry_error observed=%0b expected=%0b", tag, entry_error, m_err);
        end
    endtask

    task automatic cycle(input logic v, input logic [3:0] c, input logic r, input string tag);
        key_valid = v;
        key_code  = c;
        rst       = r;
        @(posedge clk);
        model_step(v, c, r);
        #1;
        check_outputs(tag);
        $display("%s: rst=%0b kv=%0b code=%h -> try=%0b atmpt=%02h cnt=%0d err=%0b",
                 tag, r, v, c, try_psswrd, psswrd_atmpt, digit_count, entry_error);
    endtask

    initial begin
        int r;
        logic [3:0] c;
        m_err = 0; m_send = 0; m_atmpt = 8'd0; m_idle = 0;

        cycle(0, 4'h0, 1, "reset");
        cycle(0, 4'h0, 1, "reset");

        // 8, 7, ENTER -> 87 with a pulse one cycle after ENTER
        cycle(1, 4'h8, 0, "k87_8");
        cycle(1, 4'h7, 0, "k87_7");
        cycle(1, 4'hB, 0, "k87_enter");
        n_checks++;
        assert (try_psswrd === 1'b1 && psswrd_atmpt === 8'h57) else begin
            n_fail++;
            $error("FAIL k87_pulse try=%0b atmpt=%02h expected try=1 atmpt=57", try_psswrd, psswrd_atmpt);
        end
        cycle(0, 4'h0, 0, "k87_after");

        // 5, ENTER -> 05
        cycle(1, 4'h5, 0, "k5_5");
        cycle(1, 4'hB, 0, "k5_enter");
        cycle(0, 4'h0, 0, "k5_after");

        // 1, 2, 3 -> error; ENTER and digits ignored; CLEAR recovers
        cycle(1, 4'h1, 0, "err_1");
        cycle(1, 4'h2, 0, "err_2");
        cycle(1, 4'h3, 0, "err_3");
        cycle(1, 4'hB, 0, "err_enter");
        cycle(1, 4'h4, 0, "err_digit");
        cycle(1, 4'hA, 0, "err_clear");

        // ENTER in IDLE, 0xE in D1, CLEAR in IDLE
        cycle(1, 4'hB, 0, "idle_enter");
        cycle(1, 4'hA, 0, "idle_clear");
        cycle(1, 4'h9, 0, "ign_9");
        cycle(1, 4'hE, 0, "ign_e");
        cycle(1, 4'hF, 0, "ign_f");
        cycle(1, 4'h9, 0, "ign_99");
        cycle(1, 4'hB, 0, "ign_enter99");
        cycle(1, 4'h3, 0, "send_key_ignored");

        // rst in the ENTER-sample cycle suppresses the pulse
        cycle(1, 4'h6, 0, "rst_6");
        cycle(1, 4'hB, 1, "rst_enter");
        cycle(0, 4'h0, 0, "rst_after");

`ifdef KEYPAD_TIMEOUT_EN
        cycle(1, 4'h8, 0, "to_8");
        for (int i = 0; i < T_CYC; i++) cycle(0, 4'h0, 0, "to_wait");
        cycle(1, 4'h7, 0, "to_7");
        cycle(1, 4'hB, 0, "to_enter");
        cycle(0, 4'h0, 0, "to_after");
`endif

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            c = (r < 60) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
            cycle(($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0, c,
                  ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
